// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry (main + skid) valid/ready pipeline stage.
// Optional macro IMM_GEN_CSR_EN: enables the CSR zimm type (101); otherwise 101 is reserved.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [31:0]      imm32;
    logic             ill_c;
    logic [XLEN-1:0]  imm_ext;
    logic             unused_inst_bits;

    assign unused_inst_bits = ^{in_inst[14:12], in_inst[6:0]};

    // Every format is first formed as a 32-bit sign-extended value; RV64 widens from bit 31.
    always_comb begin
        imm32 = '0;
        ill_c = 1'b0;
        case (in_type)
            3'b000: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            3'b001: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            3'b010: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
            3'b011: imm32 = {in_inst[31:12], 12'b0};
            3'b100: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                             in_inst[20], in_inst[30:21], 1'b0};
`ifdef IMM_GEN_CSR_EN
            3'b101: imm32 = {27'b0, in_inst[19:15]};
`else
            3'b101: ill_c = 1'b1;
`endif
            default: ill_c = 1'b1;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign imm_ext = {{32{imm32[31]}}, imm32};
        end else begin : g_x32
            assign imm_ext = imm32;
        end
    endgenerate

    logic             m_valid_q, m_valid_d;
    logic [XLEN-1:0]  m_imm_q,   m_imm_d;
    logic [TAG_W-1:0] m_tag_q,   m_tag_d;
    logic             m_ill_q,   m_ill_d;
    logic             s_valid_q, s_valid_d;
    logic [XLEN-1:0]  s_imm_q,   s_imm_d;
    logic [TAG_W-1:0] s_tag_q,   s_tag_d;
    logic             s_ill_q,   s_ill_d;
    logic             in_ready_q, in_ready_d;
    logic             acc, pop;

    assign acc = in_valid & in_ready_q;
    assign pop = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_imm_d   = m_imm_q;
        m_tag_d   = m_tag_q;
        m_ill_d   = m_ill_q;
        s_valid_d = s_valid_q;
        s_imm_d   = s_imm_q;
        s_tag_d   = s_tag_q;
        s_ill_d   = s_ill_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (pop && s_valid_q) begin
            m_valid_d = 1'b1;
            m_imm_d   = s_imm_q;
            m_tag_d   = s_tag_q;
            m_ill_d   = s_ill_q;
            s_valid_d = 1'b0;
        end else if (acc && (!m_valid_q || pop)) begin
            m_valid_d = 1'b1;
            m_imm_d   = imm_ext;
            m_tag_d   = in_tag;
            m_ill_d   = ill_c;
        end else if (acc) begin
            s_valid_d = 1'b1;
            s_imm_d   = imm_ext;
            s_tag_d   = in_tag;
            s_ill_d   = ill_c;
        end else if (pop) begin
            m_valid_d = 1'b0;
        end
        // Registered copy of ~S.valid so in_ready never depends combinationally on out_ready.
        in_ready_d = ~s_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            m_imm_q    <= '0;
            m_tag_q    <= '0;
            m_ill_q    <= 1'b0;
            s_valid_q  <= 1'b0;
            s_imm_q    <= '0;
            s_tag_q    <= '0;
            s_ill_q    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid_q  <= m_valid_d;
            m_imm_q    <= m_imm_d;
            m_tag_q    <= m_tag_d;
            m_ill_q    <= m_ill_d;
            s_valid_q  <= s_valid_d;
            s_imm_q    <= s_imm_d;
            s_tag_q    <= s_tag_d;
            s_ill_q    <= s_ill_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = m_valid_q;
    assign out_imm     = m_imm_q;
    assign out_tag     = m_tag_q;
    assign out_illegal = m_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance share stimulus and are checked
// against a queue-based reference model; honours IMM_GEN_CSR_EN when defined.
module tb_imm_gen_pipe;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, flush, in_valid, out_ready;
    logic [31:0]      in_inst;
    logic [2:0]       in_type;
    logic [TAG_W-1:0] in_tag;

    logic             rdy32, val32, ill32;
    logic [31:0]      imm32;
    logic [TAG_W-1:0] tag32;
    logic             rdy64, val64, ill64;
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_valid(val32),
        .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_valid(val64),
        .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64)
    );

    typedef struct packed {
        logic [63:0]      imm;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t      model_q[$];
    int          total = 0;
    int          bad = 0;
    int          accepted = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_imm = '0;

    // Immediate value computed arithmetically from field weights, then wrapped to two's complement.
    function automatic void ref_ext(input logic [31:0] inst, input logic [2:0] t,
                                    output logic [63:0] imm, output logic ill);
        longint v;
        v   = 0;
        ill = 1'b0;
        case (t)
            3'd0: begin
                v = longint'(inst[31:20]);
                if (v >= 2048) v = v - 4096;
            end
            3'd1: begin
                v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
                if (v >= 2048) v = v - 4096;
            end
            3'd2: begin
                v = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                  + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                if (v >= 4096) v = v - 8192;
            end
            3'd3: begin
                v = longint'(inst[31:12]) * 4096;
                if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
            end
            3'd4: begin
                v = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
                  + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                if (v >= 1048576) v = v - 2097152;
            end
`ifdef IMM_GEN_CSR_EN
            3'd5: v = longint'(inst[19:15]);
`endif
            default: ill = 1'b1;
        endcase
        imm = v;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic exp_rdy, exp_val;
        exp_rdy = (model_q.size() < 2);
        exp_val = (model_q.size() > 0);
        chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
        chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
        chk("out_valid32", 64'(val32), 64'(exp_val));
        chk("out_valid64", 64'(val64), 64'(exp_val));
        if (exp_val) begin
            chk("imm32", 64'(imm32), 64'(model_q[0].imm[31:0]));
            chk("imm64", imm64, model_q[0].imm);
            chk("tag32", 64'(tag32), 64'(model_q[0].tag));
            chk("tag64", 64'(tag64), 64'(model_q[0].tag));
            chk("ill32", 64'(ill32), 64'(model_q[0].ill));
            chk("ill64", 64'(ill64), 64'(model_q[0].ill));
        end
        if (prev_stall) chk("stall_hold", imm64, prev_imm);
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic v,
                                 input logic [31:0] inst, input logic [2:0] t,
                                 input logic [TAG_W-1:0] tg, input logic ordy);
        entry_t e;
        logic   acc, pop;
        @(negedge clk);
        checkOutput();
        rst       = r;
        flush     = f;
        in_valid  = v;
        in_inst   = inst;
        in_type   = t;
        in_tag    = tg;
        out_ready = ordy;
        @(posedge clk);
        acc = v && (model_q.size() < 2);
        pop = (model_q.size() > 0) && ordy;
        prev_stall = 1'b0;
        if (r || f) begin
            model_q.delete();
        end else begin
            prev_stall = (model_q.size() > 0) && !ordy;
            if (prev_stall) prev_imm = model_q[0].imm;
            if (pop) void'(model_q.pop_front());
            if (acc) begin
                ref_ext(inst, t, e.imm, e.ill);
                e.tag = tg;
                model_q.push_back(e);
                accepted++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_type = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(val32), 64'd0);
        chk("rst_in_ready", 64'(rdy64), 64'd1);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_imm32", 64'(imm32), 64'd0);
        chk("rst_tag", 64'(tag32), 64'd0);
        chk("rst_illegal", 64'(ill64), 64'd0);

        // Directed formats with downstream always ready
        applyStimulus(0, 0, 1, 32'hFFF00093, 3'd0, 5'd3, 1);
        applyStimulus(0, 0, 1, 32'h80000063, 3'd2, 5'd4, 1);
        applyStimulus(0, 0, 1, 32'h800002B7, 3'd3, 5'd5, 1);
        applyStimulus(0, 0, 1, 32'h0040006F, 3'd4, 5'd6, 1);
        applyStimulus(0, 0, 1, 32'hFE112E23, 3'd1, 5'd2, 1);
        applyStimulus(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);

        // Back-pressure: two accepts fill M and S, a third offer is refused
        applyStimulus(0, 0, 1, 32'h00100093, 3'd0, 5'd1, 0);
        applyStimulus(0, 0, 1, 32'h00200093, 3'd0, 5'd2, 0);
        applyStimulus(0, 0, 1, 32'h00300093, 3'd0, 5'd3, 0);
        applyStimulus(0, 0, 0, 32'h0, 3'd0, 5'd0, 0);
        applyStimulus(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);
        applyStimulus(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);
        applyStimulus(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);

        // Reserved and CSR types
        applyStimulus(0, 0, 1, 32'hFFFFFFFF, 3'd7, 5'd7, 1);
        applyStimulus(0, 0, 1, 32'hFFFFFFFF, 3'd6, 5'd9, 1);
        applyStimulus(0, 0, 1, 32'h000F8073, 3'd5, 5'd8, 1);
        applyStimulus(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);

        // Flush with both entries held, then flush racing an accept into an empty S
        applyStimulus(0, 0, 1, 32'h00900093, 3'd0, 5'd9, 0);
        applyStimulus(0, 0, 1, 32'h00A00093, 3'd0, 5'd10, 0);
        applyStimulus(0, 1, 1, 32'h00B00093, 3'd0, 5'd11, 0);
        applyStimulus(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);
        applyStimulus(0, 0, 1, 32'h00C00093, 3'd0, 5'd12, 0);
        applyStimulus(0, 1, 1, 32'h00D00093, 3'd0, 5'd13, 1);
        applyStimulus(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);

        // Reset in the middle of a stall
        applyStimulus(0, 0, 1, 32'h00E00093, 3'd0, 5'd14, 0);
        applyStimulus(0, 0, 1, 32'h00F00093, 3'd0, 5'd15, 0);
        applyStimulus(1, 0, 1, 32'h01000093, 3'd0, 5'd16, 0);
        applyStimulus(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);
        applyStimulus(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);

        // Random stream of 100 accepted entries against random back-pressure
        accepted = 0;
        for (int cyc = 0; cyc < 3000 && accepted < 100; cyc++) begin
            applyStimulus(0, 0, 1'($urandom_range(0, 1)), $urandom(),
                          3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 2) != 0));
        end
        chk("random_accept_count", 64'(accepted), 64'd100);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);
        @(negedge clk);
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
